// File: rtl/letc_core_pkg.sv
// Shared LETC Core types and constants for the LIMP request fabric.
// Contents: LIMP access-size encoding, arbiter FSM state encoding,
// default requester count and an index-width helper.
package letc_core_pkg;

    localparam int unsigned LIMP_DEFAULT_NUM_CH = 3;
    localparam int unsigned LIMP_SIZE_W         = 2;

    typedef enum logic [LIMP_SIZE_W-1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } limp_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } limp_arb_state_e;

    // Index width for n channels; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/letc_core_rr_picker.sv
// Combinational round-robin picker.
// Scans i_req starting at i_ptr and wrapping around; returns the first set
// index. Reusable for any rotating-priority arbiter.
// Ports:
//   i_req  [NUM_CH]  request vector
//   i_ptr  [IDX_W]   highest-priority index (must be < NUM_CH)
//   o_idx  [IDX_W]   winning index (0 when nothing requests)
//   o_any  [1]       at least one request is set
module letc_core_rr_picker
    import letc_core_pkg::*;
#(
    parameter int unsigned NUM_CH = LIMP_DEFAULT_NUM_CH,
    parameter int unsigned IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    // First hit wins; later hits are ignored once o_any is set.
    always_comb begin
        int unsigned ch;
        ch    = 0;
        o_idx = '0;
        o_any = 1'b0;
        for (int unsigned off = 0; off < NUM_CH; off++) begin
            ch = (32'(i_ptr) + off) % NUM_CH;
            if (!o_any && i_req[IDX_W'(ch)]) begin
                o_any = 1'b1;
                o_idx = IDX_W'(ch);
            end
        end
    end

endmodule

// File: rtl/letc_core_limp_arbiter.sv
// Round-robin N-to-1 arbiter for LIMP memory-request channels.
// A grant is held from selection until the downstream completion strobe;
// request fields, ready and response are steered combinationally.
// Optional macro LETC_CORE_LIMP_ARB_PERF_EN enables saturating per-channel
// completed-grant counters on o_grant_cnt (tied to 0 otherwise).
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_req_*                 per-channel request valid/type/size/addr/wdata
//   o_req_ready             per-channel one-cycle completion strobe
//   o_rsp_rdata/illegal     downstream response, broadcast to all channels
//   o_dn_*, i_dn_*          single downstream LIMP port
//   o_grant_cnt             per-channel completion counters
module letc_core_limp_arbiter
    import letc_core_pkg::*;
#(
    parameter int unsigned NUM_CH = LIMP_DEFAULT_NUM_CH,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_CH-1:0]             i_req_valid,
    output logic [NUM_CH-1:0]             o_req_ready,
    input  logic [NUM_CH-1:0]             i_req_wen_nren,
    input  logic [NUM_CH*LIMP_SIZE_W-1:0] i_req_size,
    input  logic [NUM_CH*ADDR_W-1:0]      i_req_addr,
    input  logic [NUM_CH*DATA_W-1:0]      i_req_wdata,
    output logic [DATA_W-1:0]             o_rsp_rdata,
    output logic                          o_rsp_illegal,
    output logic                          o_dn_valid,
    input  logic                          i_dn_ready,
    output logic                          o_dn_wen_nren,
    output logic [LIMP_SIZE_W-1:0]        o_dn_size,
    output logic [ADDR_W-1:0]             o_dn_addr,
    output logic [DATA_W-1:0]             o_dn_wdata,
    input  logic [DATA_W-1:0]             i_dn_rdata,
    input  logic                          i_dn_illegal,
    output logic [NUM_CH*CNT_W-1:0]       o_grant_cnt
);

    localparam int unsigned IDX_W = idx_width(NUM_CH);

    limp_arb_state_e  state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic [LIMP_SIZE_W-1:0] size_a  [NUM_CH];
    logic [ADDR_W-1:0]      addr_a  [NUM_CH];
    logic [DATA_W-1:0]      wdata_a [NUM_CH];

    // Split flattened per-channel buses for indexed selection.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign size_a[g]  = i_req_size[g*LIMP_SIZE_W +: LIMP_SIZE_W];
        assign addr_a[g]  = i_req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = i_req_wdata[g*DATA_W +: DATA_W];
    end

    letc_core_rr_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .i_req  (i_req_valid),
        .i_ptr  (rr_q),
        .o_idx  (pick_idx),
        .o_any  (pick_any)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    // Next-state: grant on any request in IDLE, release on completion.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_dn_ready) begin
                    // Pointer moves just past the served channel, wrapping at NUM_CH-1.
                    if (32'(grant_q) == NUM_CH - 1) rr_d = '0;
                    else                            rr_d = grant_q + IDX_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: granted channel steered through while BUSY, zeros in IDLE.
    always_comb begin
        o_dn_valid    = 1'b0;
        o_dn_wen_nren = 1'b0;
        o_dn_size     = '0;
        o_dn_addr     = '0;
        o_dn_wdata    = '0;
        o_req_ready   = '0;
        o_rsp_rdata   = '0;
        o_rsp_illegal = 1'b0;
        if (state_q == BUSY) begin
            o_dn_valid           = 1'b1;
            o_dn_wen_nren        = i_req_wen_nren[grant_q];
            o_dn_size            = size_a[grant_q];
            o_dn_addr            = addr_a[grant_q];
            o_dn_wdata           = wdata_a[grant_q];
            o_req_ready[grant_q] = i_dn_ready;
            o_rsp_rdata          = i_dn_rdata;
            o_rsp_illegal        = i_dn_illegal;
        end
    end

`ifdef LETC_CORE_LIMP_ARB_PERF_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Saturating completion counters.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (o_req_ready[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
        assign o_grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign o_grant_cnt = '0;
`endif

`ifndef SYNTHESIS
    // The granted requester must hold valid until its completion strobe.
    a_valid_held: assert property (@(posedge i_clk) disable iff (i_rst)
        (state_q == BUSY && !i_dn_ready) |=> i_req_valid[grant_q]);
`endif

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
module tb_letc_core_limp_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH-1:0]    req_wen;
    logic [NCH*2-1:0]  req_size;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_illegal;
    logic              dn_valid;
    logic              dn_ready;
    logic              dn_wen;
    logic [1:0]        dn_size;
    logic [AW-1:0]     dn_addr;
    logic [DW-1:0]     dn_wdata;
    logic [DW-1:0]     dn_rdata;
    logic              dn_illegal;
    logic [NCH*CW-1:0] grant_cnt;

    always #5 clk = ~clk;

    letc_core_limp_arbiter #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_wen_nren (req_wen),
        .i_req_size     (req_size),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_illegal  (rsp_illegal),
        .o_dn_valid     (dn_valid),
        .i_dn_ready     (dn_ready),
        .o_dn_wen_nren  (dn_wen),
        .o_dn_size      (dn_size),
        .o_dn_addr      (dn_addr),
        .o_dn_wdata     (dn_wdata),
        .i_dn_rdata     (dn_rdata),
        .i_dn_illegal   (dn_illegal),
        .o_grant_cnt    (grant_cnt)
    );

    typedef struct {
        int          ch;
        logic        wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
        int          lat;
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[5];
    int          n_vec = 0;
    int          n_err = 0;
    int          cnt_model[NCH];
    logic        cur_wen[NCH];
    logic [1:0]  cur_size[NCH];
    logic [31:0] cur_addr[NCH];
    logic [31:0] cur_wdata[NCH];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every completion strobe must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && req_ready !== '0) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 64'(req_ready), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ready_mask", 64'(req_ready), 64'(e.mask));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_illegal", 64'(rsp_illegal), 64'(e.ill));
                for (int c = 0; c < NCH; c++) if (e.mask[c]) cnt_model[c]++;
            end
        end
    end

    task automatic set_req(input int ch, input logic wen, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        cur_wen[ch]   = wen;
        cur_size[ch]  = size;
        cur_addr[ch]  = addr;
        cur_wdata[ch] = wdata;
        req_wen[ch]              = wen;
        req_size[ch*2 +: 2]      = size;
        req_addr[ch*AW +: AW]    = addr;
        req_wdata[ch*DW +: DW]   = wdata;
        req_valid[ch]            = 1'b1;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!dn_valid && cyc < 20);
        if (!dn_valid) chk("dn_valid_timeout", 64'(dn_valid), 64'd1);
    endtask

    // Expect channel ch granted; complete it after lat stall cycles.
    task automatic serve(input int ch, input logic [2:0] mask, input int lat,
                         input logic [31:0] rd, input logic ill, input logic keep);
        int cyc;
        wait_valid(cyc);
        chk("dn_latency", 64'(cyc), 64'd1);
        chk("dn_addr", 64'(dn_addr), 64'(cur_addr[ch]));
        chk("dn_wen", 64'(dn_wen), 64'(cur_wen[ch]));
        chk("dn_size", 64'(dn_size), 64'(cur_size[ch]));
        chk("dn_wdata", 64'(dn_wdata), 64'(cur_wdata[ch]));
        for (int k = 0; k < lat; k++) begin
            chk("early_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            #1;
            chk("stall_dn_valid", 64'(dn_valid), 64'd1);
        end
        dn_rdata   = rd;
        dn_illegal = ill;
        dn_ready   = 1'b1;
        sb.push_back('{mask, rd, ill});
        @(negedge clk);
        dn_ready   = 1'b0;
        dn_illegal = 1'b0;
        if (!keep) req_valid[ch] = 1'b0;
        #1;
        chk("idle_dn_valid", 64'(dn_valid), 64'd0);
        chk("idle_dn_addr", 64'(dn_addr), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [CW-1:0] exp_cnt;

        vt[0] = '{1, 1'b0, 2'b10, 32'h8000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3, 3'b010};
        vt[1] = '{0, 1'b0, 2'b10, 32'h0000_0100, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 0, 3'b001};
        vt[2] = '{2, 1'b1, 2'b01, 32'h4000_0002, 32'h1234_5678, 32'h0000_0000, 1'b1, 1, 3'b100};
        vt[3] = '{0, 1'b1, 2'b00, 32'h0000_0001, 32'h0000_00A5, 32'h0000_0000, 1'b0, 2, 3'b001};
        vt[4] = '{1, 1'b0, 2'b01, 32'h2000_0004, 32'h0000_0000, 32'h0000_CAFE, 1'b1, 0, 3'b010};

        for (int c = 0; c < NCH; c++) cnt_model[c] = 0;
        rst        = 1'b1;
        req_valid  = '0;
        req_wen    = '0;
        req_size   = '0;
        req_addr   = '0;
        req_wdata  = '0;
        dn_ready   = 1'b0;
        dn_rdata   = '0;
        dn_illegal = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_dn_addr", 64'(dn_addr), 64'd0);
        chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-channel transactions; vt[1] exercises the rr_ptr=2 -> ch0 wrap.
        for (int i = 0; i < 5; i++) begin
            set_req(vt[i].ch, vt[i].wen, vt[i].size, vt[i].addr, vt[i].wdata);
            serve(vt[i].ch, vt[i].exp_ready, vt[i].lat, vt[i].rdata, vt[i].ill, 1'b0);
        end

        // rr_ptr=2 now: simultaneous ch0+ch2 -> ch2 first, then ch0.
        set_req(0, 1'b0, 2'b10, 32'h0000_0A00, 32'h0);
        set_req(2, 1'b0, 2'b10, 32'h0000_0A02, 32'h0);
        serve(2, 3'b100, 0, 32'h2222_2222, 1'b0, 1'b0);
        serve(0, 3'b001, 0, 32'h0000_0000, 1'b0, 1'b0);

        // Reset mid-BUSY (rr_ptr=1 here) drops dn_valid asynchronously.
        set_req(1, 1'b0, 2'b10, 32'h0000_0B01, 32'h0);
        wait_valid(cyc);
        chk("pre_rst_latency", 64'(cyc), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        for (int c = 0; c < NCH; c++) cnt_model[c] = 0;
        repeat (2) @(negedge clk);
        chk("rst_grant_cnt2", 64'(grant_cnt), 64'd0);
        rst = 1'b0;

        // All channels continuously valid: ch0,ch1,ch2,ch0 then drain ch1,ch2.
        set_req(0, 1'b0, 2'b10, 32'h0000_0C00, 32'h0);
        set_req(1, 1'b1, 2'b10, 32'h0000_0C01, 32'h1111_0001);
        set_req(2, 1'b0, 2'b00, 32'h0000_0C02, 32'h0);
        serve(0, 3'b001, 0, 32'hC000_0000, 1'b0, 1'b1);
        serve(1, 3'b010, 0, 32'hC000_0001, 1'b0, 1'b1);
        serve(2, 3'b100, 0, 32'hC000_0002, 1'b0, 1'b1);
        serve(0, 3'b001, 0, 32'hC000_0003, 1'b1, 1'b0);
        serve(1, 3'b010, 0, 32'hC000_0004, 1'b0, 1'b0);
        serve(2, 3'b100, 0, 32'hC000_0005, 1'b0, 1'b0);

        // Twenty grants to ch0 drive its counter into saturation.
        for (int i = 0; i < 20; i++) begin
            set_req(0, 1'b0, 2'b10, 32'h0000_1000 + 32'(i), 32'h0);
            serve(0, 3'b001, 0, 32'(i), 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        #1;

        for (int c = 0; c < NCH; c++) begin
`ifdef LETC_CORE_LIMP_ARB_PERF_EN
            exp_cnt = (cnt_model[c] > 15) ? CW'(15) : CW'(cnt_model[c]);
`else
            exp_cnt = '0;
`endif
            chk($sformatf("grant_cnt_ch%0d", c), 64'(grant_cnt[c*CW +: CW]), 64'(exp_cnt));
        end
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
